// File: rtl/board_pkg.sv
// board_pkg: shared board geometry, card format, LFSR constants and one-hot
// state encoding for the board dealing sequencer.
package board_pkg;

    localparam int NUM_LOCS  = 16;
    localparam int LOC_W     = 4;
    localparam int DATA_W    = 6;
    localparam int PAIR_ID_W = 3;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

    typedef enum logic [7:0] {
        S_IDLE  = 8'h01,
        S_FILL  = 8'h02,
        S_RD_A  = 8'h04,
        S_RD_B  = 8'h08,
        S_WR_A  = 8'h10,
        S_WR_B  = 8'h20,
        S_DONE  = 8'h40,
        S_CHECK = 8'h80
    } state_t;

endpackage

// File: rtl/deal_lfsr8.sv
// deal_lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), left shift,
// loadable seed with an all-zero seed replaced so the sequence never locks up.
module deal_lfsr8
    import board_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n)
            q <= '0;
        else if (load)
            q <= (seed == 8'h00) ? SEED_ZERO_SUB : seed;
        else if (step)
            q <= {q[6:0], ^(q & LFSR_TAPS)};

endmodule

// File: rtl/board_deal_ctrl.sv
// board_deal_ctrl: fills the board RAM with 8 pairs then shuffles them with
// LFSR-driven swaps. BOARD_DEAL_VERIFY_EN adds a CHECK pass that reports Error.
module board_deal_ctrl
    import board_pkg::*;
#(
    parameter int SWAP_ROUNDS = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [7:0]        seed,
    input  logic              Ack,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic              MemWe,
    output logic [LOC_W-1:0]  MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    output logic [6:0]        state
);

    state_t st, st_n;
    logic [LOC_W-1:0]  k, i, j, chk_addr;
    logic [7:0]        r;
    logic [DATA_W-1:0] a;
    logic [3:0]        lfsr_unused;
    logic              load, step, last, chk_end;

`ifdef BOARD_DEAL_VERIFY_EN
    localparam state_t POST = S_CHECK;
`else
    localparam state_t POST = S_DONE;
`endif

    assign load  = (st == S_IDLE) && Start;
    assign step  = (st == S_WR_B);
    assign last  = (r == 8'(SWAP_ROUNDS - 1));
    assign i     = r[LOC_W-1:0];
    assign state = st[6:0];

    deal_lfsr8 u_lfsr (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .load   (load),
        .step   (step),
        .seed   (seed),
        .q      ({lfsr_unused, j})
    );

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            st <= S_IDLE;
            k  <= '0;
            r  <= '0;
            a  <= '0;
        end else begin
            st <= st_n;
            k  <= load ? '0 : (st == S_FILL) ? k + LOC_W'(1) : k;
            r  <= load ? '0 : step ? r + 8'd1 : r;
            if (st == S_RD_B)
                a <= MemRData;
        end

    always_comb begin
        st_n = st;
        case (st)
            S_IDLE:  if (Start) st_n = S_FILL;
            S_FILL:  if (k == LOC_W'(NUM_LOCS - 1)) st_n = S_RD_A;
            S_RD_A:  st_n = S_RD_B;
            S_RD_B:  st_n = S_WR_A;
            S_WR_A:  st_n = S_WR_B;
            S_WR_B:  st_n = last ? POST : S_RD_A;
            S_CHECK: if (chk_end) st_n = S_DONE;
            S_DONE:  if (Ack) st_n = S_IDLE;
            default: st_n = S_IDLE;
        endcase
    end

    // WR_A forwards the j read straight from RAM; WR_B writes the held i value.
    always_comb begin
        Busy     = st inside {S_FILL, S_RD_A, S_RD_B, S_WR_A, S_WR_B, S_CHECK};
        Done     = (st == S_DONE);
        MemWe    = st inside {S_FILL, S_WR_A, S_WR_B};
        MemAddr  = (st == S_FILL) ? k :
                   (st inside {S_RD_A, S_WR_A}) ? i :
                   (st inside {S_RD_B, S_WR_B}) ? j :
                   (st == S_CHECK) ? chk_addr : '0;
        MemWData = (st == S_FILL) ? DATA_W'(k[LOC_W-1:1]) :
                   (st == S_WR_A) ? MemRData :
                   (st == S_WR_B) ? a : '0;
    end

`ifdef BOARD_DEAL_VERIFY_EN
    logic [4:0]           c;
    logic [1:0]           hist [8];
    logic                 bad, err;
    logic [PAIR_ID_W-1:0] id;

    assign id       = MemRData[PAIR_ID_W-1:0];
    assign chk_addr = c[LOC_W-1:0];
    assign chk_end  = (c == 5'(NUM_LOCS));

    // Read data lags the address by one cycle, so c==0 carries no card.
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            c   <= '0;
            bad <= 1'b0;
            for (int n = 0; n < 8; n++) hist[n] <= '0;
        end else if (load) begin
            c   <= '0;
            bad <= 1'b0;
            for (int n = 0; n < 8; n++) hist[n] <= '0;
        end else if (st == S_CHECK) begin
            c <= c + 5'd1;
            if (c != 5'd0) begin
                if (hist[id] != 2'd3)
                    hist[id] <= hist[id] + 2'd1;
                bad <= bad | (|MemRData[DATA_W-1:PAIR_ID_W]);
            end
        end

    always_comb begin
        err = bad;
        for (int n = 0; n < 8; n++)
            err = err | (hist[n] != 2'd2);
    end

    assign Error = (st == S_DONE) && err;
`else
    assign chk_addr = '0;
    assign chk_end  = 1'b0;
    assign Error    = 1'b0;
`endif

endmodule
